touch_button_grid: RTL and testbench
====================================

Name: touch_button_grid

Overview:
- Parametrised successor to the fixed 12-button touch decoder in the equaliser UI.
- Maps touch-controller coordinates onto a ROWS x COLS grid of rectangular soft buttons.
- Debounces report edges, then emits one-cycle press, long-press, auto-repeat and release events per button.
- Sits between the touch-controller reader and the equaliser gain/preset control logic.

Parameters:
- ROWS, 4, number of button rows
- COLS, 3, number of button columns; N = ROWS*COLS
- X0, 480, left edge of column 0 (pixels)
- Y0, 160, top edge of row 0 (pixels)
- BTN_W, 85, button width; hit when X0+c*PITCH_X <= x <= X0+c*PITCH_X+BTN_W
- BTN_H, 60, button height; same rule for y with PITCH_Y
- PITCH_X, 106, column pitch
- PITCH_Y, 80, row pitch
- DEB_REPORTS, 31, qualifying reports before a press is accepted
- LONG_REPORTS, 31, further reports on the same button before long-press
- REPEAT_REPORTS, 8, reports between auto-repeat pulses while in LONG
- RELEASE_CYC, 11000000, report-free pclk cycles that mean the finger has lifted

Ports:
- pclk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- touch_int  in  1  controller interrupt; a high-to-low transition marks one coordinate report
- touch_x  in  12  touch point X, stable around the report edge
- touch_y  in  12  touch point Y
- btn_press  out  N  one-hot, 1-cycle pulse: short press accepted
- btn_long  out  N  one-hot, 1-cycle pulse: long press reached
- btn_repeat  out  N  one-hot, 1-cycle pulse: auto-repeat tick
- btn_release  out  N  one-hot, 1-cycle pulse: active button released
- btn_held  out  N  one-hot level: button owned by the FSM (PRESSED or LONG)
- active_idx  out  $clog2(N+1)  index of the tracked button; N means none

Behaviour:
- Reset, sampled on the pclk edge with rst_n=0:
  - all event outputs and btn_held are 0; active_idx = N
  - FSM goes to IDLE; all counters clear; sync flops preset to 1
- Input sync and report strobe:
  - touch_int passes through 2 flops; rpt = s2 & ~s1 (falling edge), 1 cycle wide.
- Hit decode:
  - Registered each cycle. hit_idx = r*COLS+c for the first matching cell in row-major order; N if none.
  - Latency 1 cycle, so hit_idx is valid on the cycle rpt asserts.
  - Gap pixels and out-of-grid coordinates give N. Boundaries are inclusive.
- Counters:
  - deb_cnt counts reports; rel_cnt counts pclk cycles; rep_cnt counts reports.
  - All saturate at their terminal value and never wrap.
- FSM states IDLE, ARMED, PRESSED, LONG:
  - IDLE:
    - rpt with hit_idx<N: latch active_idx=hit_idx, deb_cnt=1, go to ARMED.
    - If DEB_REPORTS==1, go straight to PRESSED instead and pulse btn_press.
  - ARMED:
    - rpt on the same idx increments deb_cnt. When it reaches DEB_REPORTS: btn_press[idx]=1 next cycle, clear rep_cnt, go to PRESSED.
    - rpt on a different valid idx restarts ARMED on the new idx with deb_cnt=1.
    - rpt with hit N, or rel_cnt reaching RELEASE_CYC: go to IDLE with no event.
  - PRESSED:
    - rpt on the same idx increments rep_cnt. When it reaches LONG_REPORTS: btn_long pulse, clear rep_cnt, go to LONG.
  - LONG:
    - rpt on the same idx increments rep_cnt. On reaching REPEAT_REPORTS: btn_repeat pulse, clear rep_cnt, stay in LONG.
  - PRESSED and LONG release:
    - rel_cnt reaching RELEASE_CYC: btn_release pulse, go to IDLE, active_idx=N.
    - A rpt on another idx or off-grid is a slide-off: btn_release pulse on the old idx, go to IDLE the same cycle. The new button needs a fresh debounce.
  - rel_cnt clears on every rpt and increments otherwise, in all non-IDLE states.
- Output exclusivity:
  - At most one bit across all event vectors is high in any cycle.
  - btn_held is high only in PRESSED and LONG.
- Reset mid-press: no release pulse is emitted.

Decomposition:
- Shared package touch_ui_pkg:
  - FSM state enum
  - report-strobe helper constants
  - default geometry constants shared with the LCD overlay renderer
- Sub-module grid_hit_decode: parametrised registered coordinate-to-index decoder, reused by the renderer's highlight logic.

Test Plan (sim parameters: DEB_REPORTS=3, LONG_REPORTS=4, REPEAT_REPORTS=2, RELEASE_CYC=100; default geometry):
- Short press: 3 reports at (500,170) every 20 cycles, then silence → btn_press[0] pulses 1 cycle after the 3rd report edge; btn_release[0] pulses 100 cycles after the last report; active_idx returns to 12.
- Long press and repeat: 11 reports at (700,420) every 20 cycles → btn_press[11] after report 3, btn_long[11] after report 7, btn_repeat[11] after reports 9 and 11; btn_held[11]=1 throughout.
- Debounce abort: 2 reports at (600,250), then silence → no event pulse; FSM back in IDLE after 100 cycles.
- Gap and boundary hits: reports at x=565 and x=566, y=200 → x=565 selects idx 0; x=566 gives hit N and produces no activity.
- Slide-off: press idx 4 (3 reports at (600,260)), then a report at (700,260) → btn_release[4] pulse; idx 5 needs 3 new reports before btn_press[5].
- Reset mid-hold: rst_n=0 for 1 cycle while in LONG → all outputs 0, active_idx=12, no release pulse; next press behaves normally.

Source files
------------

// File: rtl/touch_ui_pkg.sv
// Shared definitions for the touch button UI.
//   - FSM state and event enums used by touch_button_grid
//   - report-strobe synchroniser constants
//   - default button geometry, also used by the LCD overlay renderer
package touch_ui_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PRESSED,
        ST_LONG
    } btn_state_e;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_PRESS,
        EV_LONG,
        EV_REPEAT,
        EV_RELEASE
    } btn_event_e;

    // touch_int synchroniser: depth and idle (preset) level
    localparam int   SYNC_STAGES   = 2;
    localparam logic SYNC_IDLE_LVL = 1'b1;

    localparam int COORD_W = 12;

    // Default geometry in pixels
    localparam int DEF_ROWS    = 4;
    localparam int DEF_COLS    = 3;
    localparam int DEF_X0      = 480;
    localparam int DEF_Y0      = 160;
    localparam int DEF_BTN_W   = 85;
    localparam int DEF_BTN_H   = 60;
    localparam int DEF_PITCH_X = 106;
    localparam int DEF_PITCH_Y = 80;

endpackage

// File: rtl/grid_hit_decode.sv
// Registered coordinate-to-button decoder.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   x_i, y_i      : touch coordinates
//   hit_idx_o     : r*COLS+c of the first hit cell (row-major), ROWS*COLS if none
// Cell edges are inclusive: X0+c*PITCH_X <= x <= X0+c*PITCH_X+BTN_W.
module grid_hit_decode
    import touch_ui_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int X0      = DEF_X0,
    parameter int Y0      = DEF_Y0,
    parameter int BTN_W   = DEF_BTN_W,
    parameter int BTN_H   = DEF_BTN_H,
    parameter int PITCH_X = DEF_PITCH_X,
    parameter int PITCH_Y = DEF_PITCH_Y,
    parameter int IDX_W   = $clog2(ROWS*COLS+1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic [IDX_W-1:0]   hit_idx_o
);
    localparam int N = ROWS*COLS;

    logic [31:0]               xw, yw;
    logic [COLS-1:0]           col_hit;
    logic [ROWS-1:0]           row_hit;
    logic [N-1:0]              cell_hit;
    // chain[i] = first hit index at or above i; lowest index wins
    logic [N:0][IDX_W-1:0]     chain;
    logic [IDX_W-1:0]          hit_q;

    assign xw = {{(32-COORD_W){1'b0}}, x_i};
    assign yw = {{(32-COORD_W){1'b0}}, y_i};

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int LO = X0 + c*PITCH_X;
        assign col_hit[c] = (xw >= 32'(LO)) && (xw <= 32'(LO + BTN_W));
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam int LO = Y0 + r*PITCH_Y;
        assign row_hit[r] = (yw >= 32'(LO)) && (yw <= 32'(LO + BTN_H));
        for (genvar c = 0; c < COLS; c++) begin : g_cell
            assign cell_hit[r*COLS+c] = row_hit[r] & col_hit[c];
        end
    end

    assign chain[N] = IDX_W'(N);
    for (genvar i = 0; i < N; i++) begin : g_pri
        assign chain[i] = cell_hit[i] ? IDX_W'(i) : chain[i+1];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) hit_q <= IDX_W'(N);
        else         hit_q <= chain[0];
    end

    assign hit_idx_o = hit_q;

endmodule

// File: rtl/touch_button_grid.sv
// Touch-controller front end for a ROWS x COLS grid of soft buttons.
//   pclk, rst_n         : clock, synchronous active-low reset
//   touch_int           : controller interrupt, falling edge = one report
//   touch_x, touch_y    : report coordinates
//   btn_press/long/repeat/release : one-hot single-cycle events
//   btn_held            : one-hot level while the button is PRESSED or LONG
//   active_idx          : tracked button, N when none
module touch_button_grid
    import touch_ui_pkg::*;
#(
    parameter int ROWS           = DEF_ROWS,
    parameter int COLS           = DEF_COLS,
    parameter int X0             = DEF_X0,
    parameter int Y0             = DEF_Y0,
    parameter int BTN_W          = DEF_BTN_W,
    parameter int BTN_H          = DEF_BTN_H,
    parameter int PITCH_X        = DEF_PITCH_X,
    parameter int PITCH_Y        = DEF_PITCH_Y,
    parameter int DEB_REPORTS    = 31,
    parameter int LONG_REPORTS   = 31,
    parameter int REPEAT_REPORTS = 8,
    parameter int RELEASE_CYC    = 11000000
) (
    input  logic                             pclk,
    input  logic                             rst_n,
    input  logic                             touch_int,
    input  logic [COORD_W-1:0]               touch_x,
    input  logic [COORD_W-1:0]               touch_y,
    output logic [ROWS*COLS-1:0]             btn_press,
    output logic [ROWS*COLS-1:0]             btn_long,
    output logic [ROWS*COLS-1:0]             btn_repeat,
    output logic [ROWS*COLS-1:0]             btn_release,
    output logic [ROWS*COLS-1:0]             btn_held,
    output logic [$clog2(ROWS*COLS+1)-1:0]   active_idx
);
    localparam int N       = ROWS*COLS;
    localparam int IDX_W   = $clog2(N+1);
    localparam int DEB_W   = $clog2(DEB_REPORTS+1);
    localparam int REP_CAP = (LONG_REPORTS > REPEAT_REPORTS) ? LONG_REPORTS : REPEAT_REPORTS;
    localparam int REP_W   = $clog2(REP_CAP+1);
    localparam int REL_W   = $clog2(RELEASE_CYC+1);

    localparam logic [IDX_W-1:0] NONE_IDX = IDX_W'(N);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_REPORTS);
    localparam logic [REP_W-1:0] LONG_MAX = REP_W'(LONG_REPORTS);
    localparam logic [REP_W-1:0] RPT_MAX  = REP_W'(REPEAT_REPORTS);
    localparam logic [REP_W-1:0] REP_SAT  = REP_W'(REP_CAP);
    localparam logic [REL_W-1:0] REL_MAX  = REL_W'(RELEASE_CYC);
    localparam logic [N-1:0]     OH1      = N'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rpt;
    logic [IDX_W-1:0]       hit_idx;

    btn_state_e       state_q, state_d;
    btn_event_e       ev_q, ev_d;
    logic [IDX_W-1:0] idx_q, idx_d, ev_idx_q, ev_idx_d;
    logic [DEB_W-1:0] deb_q, deb_d, deb_inc;
    logic [REP_W-1:0] rep_q, rep_d, rep_inc;
    logic [REL_W-1:0] rel_q, rel_d, rel_inc;
    logic             same, valid, rel_done;

    // Sync flops idle high so reset never fabricates a report edge
    always_ff @(posedge pclk) begin
        if (!rst_n) sync_q <= {SYNC_STAGES{SYNC_IDLE_LVL}};
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], touch_int};
    end
    assign rpt = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];

    grid_hit_decode #(
        .ROWS(ROWS), .COLS(COLS), .X0(X0), .Y0(Y0),
        .BTN_W(BTN_W), .BTN_H(BTN_H), .PITCH_X(PITCH_X), .PITCH_Y(PITCH_Y),
        .IDX_W(IDX_W)
    ) u_hit (
        .clk_i    (pclk),
        .rst_ni   (rst_n),
        .x_i      (touch_x),
        .y_i      (touch_y),
        .hit_idx_o(hit_idx)
    );

    assign same     = (hit_idx == idx_q);
    assign valid    = (hit_idx != NONE_IDX);
    assign deb_inc  = (deb_q == DEB_MAX) ? deb_q : deb_q + 1'b1;
    assign rep_inc  = (rep_q == REP_SAT) ? rep_q : rep_q + 1'b1;
    assign rel_inc  = (rel_q == REL_MAX) ? rel_q : rel_q + 1'b1;
    // Quiet-time expiry: the count reaches RELEASE_CYC on this cycle
    assign rel_done = !rpt && (rel_inc == REL_MAX);

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ev_q     <= EV_NONE;
            idx_q    <= NONE_IDX;
            ev_idx_q <= NONE_IDX;
            deb_q    <= '0;
            rep_q    <= '0;
            rel_q    <= '0;
        end else begin
            state_q  <= state_d;
            ev_q     <= ev_d;
            idx_q    <= idx_d;
            ev_idx_q <= ev_idx_d;
            deb_q    <= deb_d;
            rep_q    <= rep_d;
            rel_q    <= rel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ev_d     = EV_NONE;
        idx_d    = idx_q;
        ev_idx_d = idx_q;
        deb_d    = deb_q;
        rep_d    = rep_q;
        rel_d    = rpt ? '0 : rel_inc;
        case (state_q)
            ST_IDLE: begin
                rel_d = '0;
                if (rpt && valid) begin
                    idx_d = hit_idx;
                    deb_d = DEB_W'(1);
                    rep_d = '0;
                    if (DEB_REPORTS == 1) begin
                        state_d  = ST_PRESSED;
                        ev_d     = EV_PRESS;
                        ev_idx_d = hit_idx;
                    end else begin
                        state_d  = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (rpt && same) begin
                    deb_d = deb_inc;
                    if (deb_inc == DEB_MAX) begin
                        state_d = ST_PRESSED;
                        ev_d    = EV_PRESS;
                        rep_d   = '0;
                    end
                end else if (rpt && valid) begin
                    idx_d = hit_idx;
                    deb_d = DEB_W'(1);
                end else if (rpt || rel_done) begin
                    state_d = ST_IDLE;
                    idx_d   = NONE_IDX;
                    rel_d   = '0;
                end
            end
            ST_PRESSED, ST_LONG: begin
                if (rpt && same) begin
                    rep_d = rep_inc;
                    if (rep_inc == ((state_q == ST_PRESSED) ? LONG_MAX : RPT_MAX)) begin
                        ev_d    = (state_q == ST_PRESSED) ? EV_LONG : EV_REPEAT;
                        rep_d   = '0;
                        state_d = ST_LONG;
                    end
                end else if (rpt || rel_done) begin
                    // slide-off or lift: the new button, if any, starts from IDLE
                    ev_d    = EV_RELEASE;
                    state_d = ST_IDLE;
                    idx_d   = NONE_IDX;
                    rel_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic [N-1:0] ev_oh;
    assign ev_oh = OH1 << ev_idx_q;

    assign btn_press   = (ev_q == EV_PRESS)   ? ev_oh : '0;
    assign btn_long    = (ev_q == EV_LONG)    ? ev_oh : '0;
    assign btn_repeat  = (ev_q == EV_REPEAT)  ? ev_oh : '0;
    assign btn_release = (ev_q == EV_RELEASE) ? ev_oh : '0;
    assign btn_held    = (state_q == ST_PRESSED || state_q == ST_LONG) ? (OH1 << idx_q) : '0;
    assign active_idx  = idx_q;

endmodule

// File: tb/tb_touch_button_grid.sv
module tb_touch_button_grid;
    localparam int N = 12;
    // event codes: type*100 + idx
    localparam int E_PRESS = 100, E_LONG = 200, E_REPEAT = 300, E_REL = 400;

    logic        pclk = 0, rst_n = 0, touch_int = 1;
    logic [11:0] touch_x = 0, touch_y = 0;
    logic [N-1:0] btn_press, btn_long, btn_repeat, btn_release, btn_held;
    logic [3:0]  active_idx;

    int n_assert = 0, n_fail = 0;
    int cyc = 0, t_drop = 0, press_cyc = 0, rel_cyc = 0;
    int sb[$];

    touch_button_grid #(
        .DEB_REPORTS(3), .LONG_REPORTS(4), .REPEAT_REPORTS(2), .RELEASE_CYC(100)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .touch_int(touch_int),
        .touch_x(touch_x), .touch_y(touch_y),
        .btn_press(btn_press), .btn_long(btn_long), .btn_repeat(btn_repeat),
        .btn_release(btn_release), .btn_held(btn_held), .active_idx(active_idx)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: every event must be the sole active bit and match the scoreboard head
    always @(negedge pclk) begin : mon
        int cnt, code;
        cnt = 0; code = 0;
        for (int i = 0; i < N; i++) begin
            if (btn_press[i])   begin cnt++; code = E_PRESS + i;  end
            if (btn_long[i])    begin cnt++; code = E_LONG + i;   end
            if (btn_repeat[i])  begin cnt++; code = E_REPEAT + i; end
            if (btn_release[i]) begin cnt++; code = E_REL + i;    end
        end
        if (cnt != 0) begin
            chk("event_exclusive", cnt, 1);
            if (code / 100 == 1) press_cyc = cyc;
            if (code / 100 == 4) rel_cyc = cyc;
            if (sb.size() == 0) chk("unexpected_event", code, 0);
            else chk("event", code, sb.pop_front());
        end
    end

    // One report: coordinates settle, touch_int falls for 3 cycles, 20-cycle period
    task automatic report(input int x, input int y);
        @(negedge pclk);
        touch_x = 12'(x); touch_y = 12'(y);
        @(negedge pclk);
        touch_int = 0; t_drop = cyc;
        repeat (3) @(negedge pclk);
        touch_int = 1;
        repeat (15) @(negedge pclk);
    endtask

    task automatic idle_wait(input string tag);
        repeat (120) @(negedge pclk);
        chk({tag, "_idle_idx"}, int'(active_idx), N);
        chk({tag, "_idle_held"}, int'(btn_held), 0);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge pclk);
        chk("rst_idx", int'(active_idx), N);
        chk("rst_events", int'(btn_press | btn_long | btn_repeat | btn_release), 0);
        chk("rst_held", int'(btn_held), 0);
        rst_n = 1;
        repeat (3) @(negedge pclk);

        // Short press on idx 0
        sb.push_back(E_PRESS + 0);
        for (int i = 0; i < 3; i++) report(500, 170);
        // drop -> sync (1) -> rpt cycle -> registered pulse: 2 cycles
        chk("press_latency", press_cyc - t_drop, 2);
        chk("short_held", int'(btn_held), 1);
        chk("short_idx", int'(active_idx), 0);
        sb.push_back(E_REL + 0);
        idle_wait("short");
        // rpt cycle is drop+1; pulse follows the 100th quiet cycle by one register
        chk("release_latency", rel_cyc - t_drop, 102);

        // Long press and repeat on idx 11
        sb.push_back(E_PRESS + 11);
        sb.push_back(E_LONG + 11);
        sb.push_back(E_REPEAT + 11);
        sb.push_back(E_REPEAT + 11);
        for (int i = 1; i <= 11; i++) begin
            report(700, 420);
            if (i >= 3) chk("long_held", int'(btn_held), 1 << 11);
        end
        chk("long_idx", int'(active_idx), 11);
        chk("long_sb", sb.size(), 0);
        sb.push_back(E_REL + 11);
        idle_wait("long");

        // Debounce abort on idx 4
        report(600, 250);
        report(600, 250);
        chk("abort_armed_idx", int'(active_idx), 4);
        chk("abort_held", int'(btn_held), 0);
        idle_wait("abort");

        // Inclusive right edge vs first gap pixel
        report(565, 200);
        chk("edge_idx", int'(active_idx), 0);
        idle_wait("edge");
        report(566, 200);
        chk("gap_idx", int'(active_idx), N);
        idle_wait("gap");

        // Slide-off from idx 4 to idx 5
        sb.push_back(E_PRESS + 4);
        for (int i = 0; i < 3; i++) report(600, 260);
        chk("slide_held4", int'(btn_held), 1 << 4);
        sb.push_back(E_REL + 4);
        report(700, 260);
        chk("slide_idx", int'(active_idx), N);
        chk("slide_held_off", int'(btn_held), 0);
        report(700, 260);
        report(700, 260);
        chk("slide_no_press", int'(btn_held), 0);
        sb.push_back(E_PRESS + 5);
        report(700, 260);
        chk("slide_held5", int'(btn_held), 1 << 5);
        sb.push_back(E_REL + 5);
        idle_wait("slide");

        // Reset while in LONG: no release
        sb.push_back(E_PRESS + 0);
        sb.push_back(E_LONG + 0);
        for (int i = 0; i < 7; i++) report(500, 170);
        chk("rsthold_held", int'(btn_held), 1);
        rst_n = 0;
        @(negedge pclk);
        rst_n = 1;
        chk("rsthold_idx", int'(active_idx), N);
        chk("rsthold_out", int'(btn_press | btn_long | btn_repeat | btn_release | btn_held), 0);
        idle_wait("rsthold");
        sb.push_back(E_PRESS + 0);
        for (int i = 0; i < 3; i++) report(500, 170);
        chk("after_rst_held", int'(btn_held), 1);
        sb.push_back(E_REL + 0);
        idle_wait("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
